// File: rtl/pt2262_pkg.sv
// Shared PT2262/PT2272 definitions: symbol codes, alpha-unit timing constants
// and the symbol-to-pulse-width mapping used by both encoder and decoder.
package pt2262_pkg;

  typedef enum logic [1:0] {
    SYM_0    = 2'b00,
    SYM_SYNC = 2'b01,
    SYM_F    = 2'b10,
    SYM_1    = 2'b11
  } symbol_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SYM,
    ST_SYNC
  } enc_state_t;

  localparam int ALPHA_SHORT   = 4;
  localparam int ALPHA_LONG    = 12;
  localparam int SUBCELL_ALPHA = 16;
  localparam int SYNC_ALPHA    = 128;
  localparam int N_SYMBOLS     = 13;

  // High widths (in alpha) of the two sub-cells of a symbol.
  typedef struct packed {
    logic [3:0] h1;
    logic [3:0] h2;
  } high_widths_t;

  function automatic high_widths_t symbol_highs(input symbol_t sym);
    high_widths_t w;
    unique case (sym)
      SYM_0:    w = '{h1: 4'(ALPHA_SHORT), h2: 4'(ALPHA_SHORT)};
      SYM_1:    w = '{h1: 4'(ALPHA_LONG),  h2: 4'(ALPHA_LONG)};
      SYM_F:    w = '{h1: 4'(ALPHA_SHORT), h2: 4'(ALPHA_LONG)};
      SYM_SYNC: w = '{h1: 4'(ALPHA_SHORT), h2: 4'd0};
      default:  w = '{h1: 4'(ALPHA_SHORT), h2: 4'(ALPHA_SHORT)};
    endcase
    return w;
  endfunction

  // Trinary pin decode; the undefined code 01 is sent as floating.
  function automatic symbol_t pin_to_symbol(input logic [1:0] pin);
    symbol_t sym;
    unique case (pin)
      2'b00:   sym = SYM_0;
      2'b11:   sym = SYM_1;
      default: sym = SYM_F;
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/pt2262_tick_gen.sv
// Alpha-tick prescaler: counts 0..CLK_DIV-1 and flags the terminal count.
// Held at zero (no tick) while hold is high, so the first alpha is full length.
module pt2262_tick_gen #(
  parameter int CLK_DIV = 250
) (
  input  logic clk,
  input  logic clear,
  input  logic hold,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] count;

  assign tick = !hold && (count == CW'(CLK_DIV - 1));

  // NOTE: sequential state is always written with <= so every register samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk) begin
    if (clear || hold) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/codificador_pt2262.sv
// PT2262-compatible encoder: 8 trinary address pins + 4 data bits + sync per word.
// Define PT2262_MIN_WORDS_EN to force at least MIN_WORDS words per transmission.
module codificador_pt2262
  import pt2262_pkg::*;
#(
  parameter int CLK_DIV   = 250,
  parameter int MIN_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] A,
  input  logic [3:0]  D,
  input  logic        send,
  output logic        cod_o,
  output logic        busy,
  output logic        word_done
);

`ifdef PT2262_MIN_WORDS_EN
  localparam bit MIN_WORDS_ON = 1'b1;
`else
  localparam bit MIN_WORDS_ON = 1'b0;
`endif
  localparam logic [3:0] MIN_W = 4'(MIN_WORDS);

  enc_state_t   state_q, state_d;
  logic [25:0]  sym_reg;
  logic [25:0]  load_word;
  logic [6:0]   alpha_q;
  logic         sub_q;
  logic [3:0]   idx_q;
  logic [3:0]   word_count_q;
  logic [3:0]   word_count_next;
  logic         tick;
  logic         alpha_last_sub;
  logic         sym_end;
  logic         sync_end;
  logic         cont;
  symbol_t      cur_sym;
  high_widths_t cur_w;
  logic [3:0]   cur_h;

  pt2262_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .clear(reset),
    .hold (state_q == ST_IDLE),
    .tick (tick)
  );

  // Word image: pins 0..7, then D[0]..D[3], then the sync code at the top.
  always_comb begin
    load_word = '0;
    for (int k = 0; k < 8; k++) begin
      load_word[2*k +: 2] = pin_to_symbol(A[2*k +: 2]);
    end
    for (int j = 0; j < 4; j++) begin
      load_word[16 + 2*j +: 2] = D[j] ? SYM_1 : SYM_0;
    end
    load_word[25:24] = SYM_SYNC;
  end

  assign cur_sym = symbol_t'(sym_reg[{idx_q, 1'b0} +: 2]);
  assign cur_w   = symbol_highs(cur_sym);
  assign cur_h   = sub_q ? cur_w.h2 : cur_w.h1;

  assign alpha_last_sub  = (alpha_q == 7'(SUBCELL_ALPHA - 1));
  assign sym_end         = (state_q == ST_SYM) && tick && alpha_last_sub && sub_q;
  assign sync_end        = (state_q == ST_SYNC) && tick && (alpha_q == 7'(SYNC_ALPHA - 1));
  assign word_count_next = (word_count_q == 4'd15) ? 4'd15 : word_count_q + 4'd1;
  assign cont            = send || (MIN_WORDS_ON && (word_count_next < MIN_W));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cod_o     = 1'b0;
    busy      = 1'b1;
    word_done = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (send) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        cod_o   = 1'b1;
        state_d = ST_SYM;
      end
      ST_SYM: begin
        cod_o = (alpha_q < {3'b000, cur_h});
        if (sym_end && (idx_q == 4'(N_SYMBOLS - 2))) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        cod_o = (alpha_q < {3'b000, cur_w.h1});
        if (sync_end) begin
          word_done = 1'b1;
          state_d   = cont ? ST_LOAD : ST_IDLE;
        end
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sym_reg      <= '0;
      alpha_q      <= '0;
      sub_q        <= 1'b0;
      idx_q        <= '0;
      word_count_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          alpha_q      <= '0;
          sub_q        <= 1'b0;
          idx_q        <= '0;
          word_count_q <= '0;
        end
        ST_LOAD: begin
          sym_reg <= load_word;
          // The LOAD clk is the first clk of alpha 0.
          alpha_q <= {6'd0, tick};
          sub_q   <= 1'b0;
          idx_q   <= '0;
        end
        ST_SYM: begin
          if (tick) begin
            if (alpha_last_sub) begin
              alpha_q <= '0;
              sub_q   <= ~sub_q;
              if (sub_q) idx_q <= idx_q + 4'd1;
            end else begin
              alpha_q <= alpha_q + 7'd1;
            end
          end
        end
        ST_SYNC: begin
          if (tick) alpha_q <= alpha_q + 7'd1;
          if (sync_end) word_count_q <= word_count_next;
        end
        default: begin
          alpha_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_codificador_pt2262.sv
// Directed bench for codificador_pt2262 with a short alpha (CLK_DIV=4); every
// clk of each word is compared against a per-alpha model of the PT2262 format.
module tb_codificador_pt2262;

  localparam int DIV      = 4;
  localparam int MIN_W    = 4;
  localparam int WORD_CLK = 512 * DIV;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] A;
  logic [3:0]  D;
  logic        send;
  logic        cod_o;
  logic        busy;
  logic        word_done;

  int n_checks = 0;
  int n_pass   = 0;

  codificador_pt2262 #(
    .CLK_DIV  (DIV),
    .MIN_WORDS(MIN_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .A        (A),
    .D        (D),
    .send     (send),
    .cod_o    (cod_o),
    .busy     (busy),
    .word_done(word_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Pulse high width in alpha for a 2-bit code in sub-cell 0 or 1.
  function automatic int high_alpha(input logic [1:0] code, input int sub);
    if (code == 2'b00) return 4;
    if (code == 2'b11) return 12;
    return (sub == 0) ? 4 : 12;
  endfunction

  function automatic int words_for(input int cont_ends);
`ifdef PT2262_MIN_WORDS_EN
    return (cont_ends + 1 < MIN_W) ? MIN_W : cont_ends + 1;
`else
    return cont_ends + 1;
`endif
  endfunction

  // Entered at the negedge inside the word's first (LOAD) clk; leaves at the
  // negedge one word later.
  task automatic check_word(input string tag, input logic [15:0] a, input logic [3:0] d,
                            input logic send_mid);
    logic [1:0] code [12];
    int mism [13];
    int hi [12][2];
    int wd_count, wd_at, busy_bad, al, s, w, sub, exp_bit;
    logic [3:0] d_dec;
    for (int k = 0; k < 8; k++) code[k] = a[2*k +: 2];
    for (int j = 0; j < 4; j++) code[8+j] = d[j] ? 2'b11 : 2'b00;
    for (int k = 0; k < 13; k++) mism[k] = 0;
    for (int k = 0; k < 12; k++) begin
      hi[k][0] = 0;
      hi[k][1] = 0;
    end
    wd_count = 0;
    wd_at    = -1;
    busy_bad = 0;
    for (int c = 0; c < WORD_CLK; c++) begin
      al = c / DIV;
      sub = 0;
      if (al < 384) begin
        s   = al / 32;
        w   = al % 32;
        sub = w / 16;
        exp_bit = ((w % 16) < high_alpha(code[s], sub)) ? 1 : 0;
      end else begin
        s = 12;
        exp_bit = ((al - 384) < 4) ? 1 : 0;
      end
      if (cod_o !== exp_bit[0]) mism[s]++;
      if (cod_o === 1'b1 && s < 12) hi[s][sub]++;
      if (busy !== 1'b1) busy_bad++;
      if (word_done === 1'b1) begin
        wd_count++;
        wd_at = c;
      end
      if (c == 1000) send = send_mid;
      @(negedge clk);
    end
    for (int k = 0; k < 13; k++) check($sformatf("%s sym%0d bad clks", tag, k), mism[k], 0);
    check({tag, " busy low clks"}, busy_bad, 0);
    check({tag, " word_done pulses"}, wd_count, 1);
    check({tag, " word_done clk"}, wd_at, WORD_CLK - 1);
    for (int j = 0; j < 4; j++) d_dec[j] = (hi[8+j][0] > 8 * DIV);
    check({tag, " decoded D"}, {28'd0, d_dec}, {28'd0, d});
  endtask

  // Runs all words of one transmission from the first LOAD clk onward;
  // send is high at the end of the first cont_ends words.
  task automatic run_words(input string tag, input logic [15:0] a, input logic [3:0] d,
                           input int cont_ends);
    int n;
    n = words_for(cont_ends);
    for (int w = 0; w < n; w++) begin
      check_word($sformatf("%s w%0d", tag, w), a, d, (w < cont_ends));
    end
    check({tag, " busy after"}, {31'd0, busy}, 0);
    check({tag, " cod_o after"}, {31'd0, cod_o}, 0);
  endtask

  task automatic run_tx(input string tag, input logic [15:0] a, input logic [3:0] d,
                        input int cont_ends);
    A    = a;
    D    = d;
    send = 1'b1;
    @(negedge clk);
    send = (cont_ends > 0);
    run_words(tag, a, d, cont_ends);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    send  = 1'b0;
    A     = '0;
    D     = '0;
    @(negedge clk);
    check("rst cod_o", {31'd0, cod_o}, 0);
    check("rst busy", {31'd0, busy}, 0);
    check("rst word_done", {31'd0, word_done}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle busy", {31'd0, busy}, 0);

    run_tx("zeros", 16'h0000, 4'h0, 0);
    run_tx("ones", 16'hFFFF, 4'hF, 0);
    run_tx("floats", 16'hAAAA, 4'hA, 0);
    run_tx("pin3_01", 16'hAA6A, 4'h5, 0);
    run_tx("held3", 16'h5C30, 4'h6, 2);
    run_tx("held6", 16'h0F3C, 4'h9, 5);

    // Reset during the high phase of symbol 5, then a fresh word.
    A    = 16'h0000;
    D    = 4'h3;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    repeat (648) @(negedge clk);
    check("pre-reset cod_o", {31'd0, cod_o}, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid-reset cod_o", {31'd0, cod_o}, 0);
    check("mid-reset busy", {31'd0, busy}, 0);
    reset = 1'b0;
    A     = 16'hC3F0;
    D     = 4'hC;
    send  = 1'b1;
    @(negedge clk);
    send = 1'b0;
    run_words("after_rst", 16'hC3F0, 4'hC, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
